// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry pipeline stage buffer.
// Holds the occupancy-state encoding and the default payload width.
package pipe_pkg;

  localparam int WIDTH_DEF = 92;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_entry.sv
// One payload register of the stage buffer.
// A masked clear wins over a load, so a flush discards any concurrent write.
module pipe_entry #(
  parameter int               WIDTH     = pipe_pkg::WIDTH_DEF,
  parameter logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = data_q & ~CTRL_MASK;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry skid buffer stage with stall, masked flush and a saturating
// stall-cycle counter. Handshake outputs decode only the registered state.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH            = WIDTH_DEF,
  parameter logic [WIDTH-1:0] CTRL_MASK        = {WIDTH{1'b1}},
  parameter int               FLUSH_OVER_STALL = 1,
  parameter int               CNT_W            = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic FOS = (FLUSH_OVER_STALL != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             push, pop, flush_eff;
  logic             main_ld, skid_ld, main_from_skid;
  logic [WIDTH-1:0] main_q, skid_q, main_in;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;
  assign out_data  = main_q;

  assign push      = in_valid & in_ready & ~stall;
  assign pop       = out_valid & out_ready & ~stall;
  assign flush_eff = flush & (FOS | ~stall);
  assign main_in   = main_from_skid ? skid_q : in_data;

  // Loads are only raised outside a flush, so dropped input never lands.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush_eff) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_HALF;
            main_ld = 1'b1;
          end
        end
        ST_HALF: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d        = ST_HALF;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && out_valid && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_entry #(.WIDTH(WIDTH), .CTRL_MASK(CTRL_MASK)) u_main (
    .clk   (clk),
    .rst_n (reset),
    .load  (main_ld),
    .clr   (flush_eff),
    .d     (main_in),
    .q     (main_q)
  );

  pipe_entry #(.WIDTH(WIDTH), .CTRL_MASK(CTRL_MASK)) u_skid (
    .clk   (clk),
    .rst_n (reset),
    .load  (skid_ld),
    .clr   (flush_eff),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: two instances share stimulus, one with
// flush-over-stall and an 8-bit counter, one without and a 2-bit counter.
module tb_pipe_stage_buf;
  localparam int W = 92;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, out_ready, stall, flush;
  logic [W-1:0] in_data;
  logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [W-1:0] out_data_a, out_data_b;
  logic [1:0]   occ_a, occ_b;
  logic [7:0]   cnt_a;
  logic [1:0]   cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(W), .CTRL_MASK(92'h3), .FLUSH_OVER_STALL(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .stall(stall),
    .flush(flush), .occupancy(occ_a), .stall_cnt(cnt_a));

  pipe_stage_buf #(.WIDTH(W), .CTRL_MASK(92'h3), .FLUSH_OVER_STALL(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .stall(stall),
    .flush(flush), .occupancy(occ_b), .stall_cnt(cnt_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); in_valid = 1'b1; in_data = 92'h77;
    tick(); tick();
    checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occ_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready_a); end
    checks++; if (out_data_a !== '0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data_a); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", cnt_a); end
    reset = 1'b1; in_data = 92'h5A;
    tick();
    checks++; if (out_data_a !== 92'h5A || out_valid_a !== 1'b1) begin errors++; $display("FAIL first_push got=%h/%b exp=5a/1", out_data_a, out_valid_a); end
    checks++; if (occ_b !== 2'd1) begin errors++; $display("FAIL first_push_occ_b got=%0d exp=1", occ_b); end
    idle(); out_ready = 1'b1;
    tick();
    checks++; if (occ_a !== 2'd0 || out_valid_a !== 1'b0) begin errors++; $display("FAIL first_pop got=%0d/%b exp=0/0", occ_a, out_valid_a); end
  endtask

  task automatic test_fill_drain();
    idle(); in_valid = 1'b1; in_data = 92'h111;
    tick();
    in_data = 92'h222;
    tick();
    checks++; if (occ_a !== 2'd2 || in_ready_a !== 1'b0) begin errors++; $display("FAIL fill_full got=%0d/%b exp=2/0", occ_a, in_ready_a); end
    checks++; if (out_data_a !== 92'h111) begin errors++; $display("FAIL fill_head got=%h exp=111", out_data_a); end
    idle(); out_ready = 1'b1;
    tick();
    checks++; if (out_data_a !== 92'h222 || occ_a !== 2'd1) begin errors++; $display("FAIL drain_b got=%h/%0d exp=222/1", out_data_a, occ_a); end
    tick();
    checks++; if (occ_a !== 2'd0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL drain_empty got=%0d/%b/%b exp=0/0/1", occ_a, out_valid_a, in_ready_a); end
  endtask

  task automatic test_half_pass();
    idle(); in_valid = 1'b1; in_data = 92'h0A1;
    tick();
    out_ready = 1'b1; in_data = 92'h0B2;
    tick();
    checks++; if (out_data_a !== 92'h0B2 || occ_a !== 2'd1) begin errors++; $display("FAIL half_push_pop got=%h/%0d exp=0b2/1", out_data_a, occ_a); end
    idle(); out_ready = 1'b1;
    tick();
  endtask

  task automatic test_stall();
    idle(); in_valid = 1'b1; in_data = 92'h333;
    tick();
    in_data = 92'h444;
    tick();
    stall = 1'b1; out_ready = 1'b1; in_data = 92'h999;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (occ_a !== 2'd2 || out_data_a !== 92'h333) begin errors++; $display("FAIL stall_hold got=%0d/%h exp=2/333", occ_a, out_data_a); end
    checks++; if (cnt_a !== 8'd5) begin errors++; $display("FAIL stall_cnt got=%0d exp=5", cnt_a); end
    checks++; if (cnt_b !== 2'd3) begin errors++; $display("FAIL stall_cnt_sat got=%0d exp=3", cnt_b); end
    idle(); out_ready = 1'b1;
    tick();
    checks++; if (out_data_a !== 92'h444 || occ_a !== 2'd1) begin errors++; $display("FAIL stall_resume got=%h/%0d exp=444/1", out_data_a, occ_a); end
    tick();
    checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL stall_drain got=%0d exp=0", occ_a); end
  endtask

  task automatic test_flush_priority();
    idle(); in_valid = 1'b1; in_data = 92'h1F7;
    tick();
    in_data = 92'h2AB;
    tick();
    flush = 1'b1; in_data = 92'hC0C;
    tick();
    checks++; if (occ_a !== 2'd0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL flush_empty got=%0d/%b/%b exp=0/0/1", occ_a, out_valid_a, in_ready_a); end
    checks++; if (out_data_a !== 92'h1F4) begin errors++; $display("FAIL flush_mask got=%h exp=1f4", out_data_a); end
    checks++; if (occ_b !== 2'd0 || out_data_b !== 92'h1F4) begin errors++; $display("FAIL flush_b got=%0d/%h exp=0/1f4", occ_b, out_data_b); end
    idle();
    tick();
    checks++; if (occ_a !== 2'd0 || out_data_a !== 92'h1F4) begin errors++; $display("FAIL flush_dropped got=%0d/%h exp=0/1f4", occ_a, out_data_a); end
  endtask

  task automatic test_flush_mode();
    idle(); in_valid = 1'b1; in_data = 92'h155;
    tick();
    in_data = 92'h2AA;
    tick();
    idle(); flush = 1'b1; stall = 1'b1;
    tick();
    checks++; if (occ_a !== 2'd0 || out_data_a !== 92'h154) begin errors++; $display("FAIL fos1_flush got=%0d/%h exp=0/154", occ_a, out_data_a); end
    checks++; if (occ_b !== 2'd2 || out_data_b !== 92'h155) begin errors++; $display("FAIL fos0_hold got=%0d/%h exp=2/155", occ_b, out_data_b); end
    checks++; if (cnt_a !== 8'd6) begin errors++; $display("FAIL flush_keeps_cnt got=%0d exp=6", cnt_a); end
    idle();
    tick();
    checks++; if (occ_b !== 2'd2) begin errors++; $display("FAIL fos0_not_remembered got=%0d exp=2", occ_b); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data_b !== 92'h2AA || occ_b !== 2'd1) begin errors++; $display("FAIL fos0_drain got=%h/%0d exp=2aa/1", out_data_b, occ_b); end
    tick();
    checks++; if (occ_b !== 2'd0) begin errors++; $display("FAIL fos0_empty got=%0d exp=0", occ_b); end
  endtask

  task automatic test_saturation();
    idle(); reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (cnt_b !== 2'd0) begin errors++; $display("FAIL sat_reset got=%0d exp=0", cnt_b); end
    in_valid = 1'b1; in_data = 92'h0AB;
    tick();
    idle(); stall = 1'b1;
    tick(); tick();
    checks++; if (cnt_b !== 2'd2) begin errors++; $display("FAIL sat_mid got=%0d exp=2", cnt_b); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (cnt_b !== 2'd3) begin errors++; $display("FAIL sat_hold got=%0d exp=3", cnt_b); end
    checks++; if (cnt_a !== 8'd6) begin errors++; $display("FAIL sat_wide got=%0d exp=6", cnt_a); end
    idle(); out_ready = 1'b1;
    tick();
    checks++; if (cnt_b !== 2'd3 || occ_b !== 2'd0) begin errors++; $display("FAIL sat_after got=%0d/%0d exp=3/0", cnt_b, occ_b); end
  endtask

  initial begin
    reset = 1'b0; in_data = '0; idle();
    test_reset();
    test_fill_drain();
    test_half_pass();
    test_stall();
    test_flush_priority();
    test_flush_mode();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 92, meaning the data width in bits.
REQ-002 The block SHALL have parameter CTRL_MASK, default {WIDTH{1'b1}}, meaning the bits cleared by flush; all other bits hold their value.
REQ-003 The block SHALL have parameter FLUSH_OVER_STALL, default 1, meaning: 1 = flush takes effect during stall; 0 = flush is ignored while stall=1.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning the width of the stall-cycle counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous reset, active-low.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the stage can accept data; registered.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the head entry is valid; registered.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: the head entry payload; registered.
REQ-013 The block SHALL have port stall, input, 1 bit: freeze the stage.
REQ-014 The block SHALL have port flush, input, 1 bit: discard the contents.
REQ-015 The block SHALL have port occupancy, output, 2 bits: number of valid entries (0..2).
REQ-016 The block SHALL have port stall_cnt, output, CNT_W bits: saturating count of stalled cycles.

Function
REQ-017 The block SHALL hold two entries: main, which drives out_data, and skid; the state SHALL be EMPTY (0 entries), HALF (main valid) or FULL (main and skid valid).
REQ-018 The block SHALL define push = in_valid & in_ready & ~stall, and pop = out_valid & out_ready & ~stall.
REQ-019 The block SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both derived from registered state only.
REQ-020 The block SHALL make these transitions: EMPTY + push -> HALF with main<=in_data; HALF + push & ~pop -> FULL with skid<=in_data; HALF + pop & ~push -> EMPTY; HALF + push & pop -> HALF with main<=in_data; FULL + pop -> HALF with main<=skid; all other cases hold.
REQ-021 The block SHALL have an in-to-out latency of 1 cycle: data pushed at edge N appears on out_data/out_valid after edge N.
REQ-022 While stall=1, the block SHALL perform no push or pop; state and data SHALL hold, apart from the flush behaviour in REQ-023.
REQ-023 The effective flush SHALL be flush & (FLUSH_OVER_STALL | ~stall); on an effective flush, the next state SHALL be EMPTY, the CTRL_MASK bits of main and skid SHALL be cleared, and the other bits SHALL hold.
REQ-024 An effective flush SHALL take priority over a simultaneous push or pop; the in_data offered in that cycle SHALL be dropped and SHALL NOT be counted as accepted.
REQ-025 With FLUSH_OVER_STALL=0, a flush during stall SHALL be ignored entirely and SHALL NOT be remembered.
REQ-026 When EMPTY, out_data SHALL continue to show the main register contents, including any masked bits.
REQ-027 stall_cnt SHALL increment on each cycle with stall=1 and out_valid=1, SHALL saturate at 2^CNT_W-1, and SHALL NOT be cleared by flush.
REQ-028 occupancy SHALL equal 0, 1 or 2 for EMPTY, HALF or FULL respectively.

Reset
REQ-029 When reset=0, asynchronously: state SHALL become EMPTY, main and skid SHALL be zero, stall_cnt SHALL be zero, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-030 Reset SHALL override flush, stall and push; after reset deasserts, the first accept SHALL occur at the next rising edge with push=1.

Structure
REQ-031 The state encoding (EMPTY=2'd0, HALF=2'd1, FULL=2'd2) and the WIDTH default 92 SHALL live in the shared package pipe_pkg.
REQ-032 The block SHALL instantiate sub-module pipe_entry (a WIDTH register with a load port and a masked-clear port) twice, once for main and once for skid.

Verification
REQ-033 Reset check: hold reset=0 with in_valid=1 -> occupancy=0, out_valid=0, in_ready=1, out_data=0; after release, push 0x5A -> out_data=0x5A one cycle later.
REQ-034 Fill and drain: push A, B with out_ready=0 -> FULL, in_ready=0; then out_ready=1 -> A then B on consecutive cycles, then EMPTY.
REQ-035 Stall freeze: with state FULL, stall=1 for 5 cycles with out_ready=1 -> no change, stall_cnt=5; release -> drain resumes.
REQ-036 Flush priority: with FULL and CTRL_MASK=0x3, flush and push C in the same cycle -> EMPTY, C dropped, low 2 bits of out_data=0 and upper bits unchanged.
REQ-037 Mode: with FLUSH_OVER_STALL=0, apply flush=1 and stall=1 -> contents retained; with FLUSH_OVER_STALL=1 -> EMPTY.
REQ-038 Saturation: with CNT_W=2, hold stall for 6 valid cycles -> stall_cnt=3.
